// File: rtl/csr_machine_unit_if.sv
// Pipeline-facing bundle for the machine-mode CSR unit: CSR access port,
// trap/mret sequencing, counters, interrupts and fetch redirect.
interface csr_machine_unit_if #(
   parameter int unsigned NUM_LOCAL_IRQ = 4
);
   logic [11:0]              csr_addr;
   logic [1:0]               csr_op;
   logic                     csr_re;
   logic [31:0]              csr_wdata;
   logic [31:0]              csr_rdata;
   logic                     csr_illegal;
   logic                     trap;
   logic [31:0]              trap_cause;
   logic [31:0]              trap_pc;
   logic                     mret;
   logic                     instret;
   logic [NUM_LOCAL_IRQ+2:0] irq;
   logic [31:0]              trap_target;
   logic [31:0]              mepc;
   logic                     irq_pending;
   logic                     in_handler;
   logic                     double_fault;

   modport master (
      output csr_addr, csr_op, csr_re, csr_wdata, trap, trap_cause, trap_pc,
             mret, instret, irq,
      input  csr_rdata, csr_illegal, trap_target, mepc, irq_pending,
             in_handler, double_fault
   );

   modport slave (
      input  csr_addr, csr_op, csr_re, csr_wdata, trap, trap_cause, trap_pc,
             mret, instret, irq,
      output csr_rdata, csr_illegal, trap_target, mepc, irq_pending,
             in_handler, double_fault
   );
endinterface

// File: rtl/csr_machine_unit.sv
// Machine-mode CSR unit: CSR read/write/set/clear, illegal-access detection,
// trap entry / mret sequencing, 64-bit counters and interrupt pending logic.
module csr_machine_unit #(
   parameter int unsigned NUM_LOCAL_IRQ = 4,
   parameter logic [31:0] HART_ID       = 32'h0000_0000,
   parameter logic [31:0] MVENDOR_ID    = 32'h0000_0000,
   parameter logic [31:0] MISA_VALUE    = 32'h4000_0100,
   parameter logic [31:0] MTVEC_RESET   = 32'h0000_0100,
   parameter bit          COUNTERS_EN   = 1'b1
) (
   input logic              clk,
   input logic              rst,
   csr_machine_unit_if.slave bus
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned CW   = 64;

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MIP       = 12'h344;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MVENDORID = 12'hF11;
   localparam logic [11:0] A_MARCHID   = 12'hF12;
   localparam logic [11:0] A_MIMPID    = 12'hF13;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SET   = 2'b10;

   // MSIP/MTIP/MEIP plus the local lines at 16 and up
   localparam logic [XLEN-1:0] IRQ_MASK =
      32'h0000_0888 | XLEN'(((33'h1 << NUM_LOCAL_IRQ) - 33'h1) << 16);

   typedef enum logic {RUN, HANDLER} state_t;

   state_t            state_q, state_d;
   logic              mstatus_mie_q, mstatus_mpie_q;
   logic [XLEN-1:0]   mepc_q, mcause_q, mie_q, mtvec_q, mscratch_q, mip_q;
   logic [CW-1:0]     cycle_q, instret_q;
   logic [XLEN-1:0]   rdata_q;
   logic              illegal_q, double_fault_q;

   logic [XLEN-1:0]   csr_old, csr_new, mstatus_rd, mip_d, tvec_base;
   logic              mapped, read_only, access_illegal, mret_illegal;
   logic              wr_en, mret_take;

   assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

   // Address decode and current value of the addressed CSR
   always_comb begin
      csr_old   = '0;
      mapped    = 1'b1;
      read_only = 1'b0;
      case (bus.csr_addr)
         A_MSTATUS:   csr_old = mstatus_rd;
         A_MISA:      begin csr_old = MISA_VALUE; read_only = 1'b1; end
         A_MIE:       csr_old = mie_q;
         A_MTVEC:     csr_old = mtvec_q;
         A_MSCRATCH:  csr_old = mscratch_q;
         A_MEPC:      csr_old = mepc_q;
         A_MCAUSE:    csr_old = mcause_q;
         A_MIP:       csr_old = mip_q;
         A_MCYCLE:    csr_old = cycle_q[31:0];
         A_MCYCLEH:   csr_old = cycle_q[63:32];
         A_MINSTRET:  csr_old = instret_q[31:0];
         A_MINSTRETH: csr_old = instret_q[63:32];
         A_MVENDORID: begin csr_old = MVENDOR_ID; read_only = 1'b1; end
         A_MARCHID:   read_only = 1'b1;
         A_MIMPID:    read_only = 1'b1;
         A_MHARTID:   begin csr_old = HART_ID; read_only = 1'b1; end
         default:     mapped = 1'b0;
      endcase
   end

   always_comb begin
      case (bus.csr_op)
         OP_WRITE: csr_new = bus.csr_wdata;
         OP_SET:   csr_new = csr_old | bus.csr_wdata;
         default:  csr_new = csr_old & ~bus.csr_wdata;
      endcase
   end

   assign access_illegal = ((bus.csr_op != OP_NONE || bus.csr_re) && !mapped) ||
                           (bus.csr_op != OP_NONE && read_only);
   // Traps take priority, so a coincident write is dropped (its illegal check is not)
   assign wr_en        = (bus.csr_op != OP_NONE) && mapped && !read_only && !bus.trap;
   assign mret_take    = bus.mret && !bus.trap && (state_q == HANDLER);
   assign mret_illegal = bus.mret && !bus.trap && (state_q == RUN);

   always_comb begin
      mip_d                          = '0;
      mip_d[3]                       = bus.irq[0];
      mip_d[7]                       = bus.irq[1];
      mip_d[11]                      = bus.irq[2];
      mip_d[16 +: NUM_LOCAL_IRQ]     = bus.irq[3 +: NUM_LOCAL_IRQ];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (bus.trap) state_d = HANDLER;
         HANDLER: if (!bus.trap && bus.mret) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // CSR state, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mie_q          <= '0;
         mtvec_q        <= MTVEC_RESET;
         mscratch_q     <= '0;
         mip_q          <= '0;
         cycle_q        <= '0;
         instret_q      <= '0;
         rdata_q        <= '0;
         illegal_q      <= 1'b0;
         double_fault_q <= 1'b0;
      end else begin
         mip_q     <= mip_d;
         illegal_q <= access_illegal | mret_illegal;
         if (bus.csr_re) rdata_q <= mapped ? csr_old : '0;

         if (bus.trap) begin
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
            mepc_q         <= bus.trap_pc & ~XLEN'(3);
            mcause_q       <= bus.trap_cause;
            if (state_q == HANDLER) double_fault_q <= 1'b1;
         end else begin
            if (mret_take) begin
               mstatus_mie_q  <= mstatus_mpie_q;
               mstatus_mpie_q <= 1'b1;
            end else if (wr_en && bus.csr_addr == A_MSTATUS) begin
               mstatus_mie_q  <= csr_new[3];
               mstatus_mpie_q <= csr_new[7];
            end
            if (wr_en) begin
               case (bus.csr_addr)
                  A_MIE:      mie_q      <= csr_new & IRQ_MASK;
                  A_MTVEC:    mtvec_q    <= {csr_new[31:2], 1'b0, (csr_new[1:0] == 2'b01)};
                  A_MSCRATCH: mscratch_q <= csr_new;
                  A_MEPC:     mepc_q     <= csr_new & ~XLEN'(3);
                  A_MCAUSE:   mcause_q   <= csr_new;
                  default:    ;
               endcase
            end
         end

         // A write to either half replaces it and skips that counter's increment
         if (!COUNTERS_EN)                         cycle_q         <= '0;
         else if (wr_en && bus.csr_addr == A_MCYCLE)  cycle_q[31:0]  <= csr_new;
         else if (wr_en && bus.csr_addr == A_MCYCLEH) cycle_q[63:32] <= csr_new;
         else                                      cycle_q         <= cycle_q + CW'(1);

         if (!COUNTERS_EN)                            instret_q         <= '0;
         else if (wr_en && bus.csr_addr == A_MINSTRET)  instret_q[31:0]  <= csr_new;
         else if (wr_en && bus.csr_addr == A_MINSTRETH) instret_q[63:32] <= csr_new;
         else if (bus.instret)                        instret_q         <= instret_q + CW'(1);
      end
   end

   assign tvec_base = {mtvec_q[31:2], 2'b00};

   // Vectored mode offsets interrupts by 4*cause
   always_comb begin
      bus.trap_target = tvec_base;
      if (mtvec_q[1:0] == 2'b01 && bus.trap_cause[31])
         bus.trap_target = tvec_base + XLEN'({bus.trap_cause[30:0], 2'b00});
   end

   assign bus.csr_rdata    = rdata_q;
   assign bus.csr_illegal  = illegal_q;
   assign bus.mepc         = mepc_q;
   assign bus.in_handler   = (state_q == HANDLER);
   assign bus.double_fault = double_fault_q;
   assign bus.irq_pending  = mstatus_mie_q && (|(mip_q & mie_q)) && (state_q == RUN);
endmodule

// File: tb/tb_csr_machine_unit.sv
// Directed bench for csr_machine_unit with a per-cycle behavioural CSR model
// plus literal expectations for the key scenarios.
module tb_csr_machine_unit;
   localparam int unsigned NL        = 4;
   localparam logic [31:0] HART      = 32'h0000_0005;
   localparam logic [31:0] VENDOR    = 32'h0000_0000;
   localparam logic [31:0] MISA      = 32'h4000_0100;
   localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
   localparam logic [31:0] IMPL      = 32'h000F_0888;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   csr_machine_unit_if #(.NUM_LOCAL_IRQ(NL)) bus ();

   csr_machine_unit #(
      .NUM_LOCAL_IRQ(NL), .HART_ID(HART), .MVENDOR_ID(VENDOR),
      .MISA_VALUE(MISA), .MTVEC_RESET(MTVEC_RST), .COUNTERS_EN(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model state
   bit          m_mie, m_mpie, m_hnd, m_df, m_ill;
   logic [31:0] m_mepc, m_mcause, m_mier, m_mtvec, m_mscratch, m_mip, m_rdata;
   logic [63:0] m_cyc, m_ins;

   function automatic void mread(input logic [11:0] a, output logic [31:0] v,
                                 output bit known, output bit ro);
      known = 1'b1; ro = 1'b0; v = 32'h0;
      case (a)
         12'h300: v = 32'h0000_1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
         12'h301: begin v = MISA;   ro = 1'b1; end
         12'h304: v = m_mier;
         12'h305: v = m_mtvec;
         12'h340: v = m_mscratch;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'h344: v = m_mip;
         12'hB00: v = m_cyc[31:0];
         12'hB80: v = m_cyc[63:32];
         12'hB02: v = m_ins[31:0];
         12'hB82: v = m_ins[63:32];
         12'hF11: begin v = VENDOR; ro = 1'b1; end
         12'hF12: ro = 1'b1;
         12'hF13: ro = 1'b1;
         12'hF14: begin v = HART;   ro = 1'b1; end
         default: known = 1'b0;
      endcase
   endfunction

   always @(posedge clk) begin : model
      logic [31:0] old, nv, wd;
      logic [63:0] pc_cyc, pc_ins;
      bit          known, ro, wr, mret_ok;
      logic [1:0]  op;
      if (rst) begin
         m_mie = 0; m_mpie = 0; m_hnd = 0; m_df = 0; m_ill = 0;
         m_mepc = 0; m_mcause = 0; m_mier = 0; m_mtvec = MTVEC_RST;
         m_mscratch = 0; m_mip = 0; m_rdata = 0; m_cyc = 0; m_ins = 0;
      end else begin
         mread(bus.csr_addr, old, known, ro);
         op = bus.csr_op;
         wd = bus.csr_wdata;
         nv = (op == 2'd1) ? wd : (op == 2'd2) ? (old | wd) : (old & ~wd);
         wr = (op != 2'd0) && known && !ro && !bus.trap;
         mret_ok = bus.mret && !bus.trap && m_hnd;
         m_ill = (((op != 2'd0) || bus.csr_re) && !known) || ((op != 2'd0) && ro) ||
                 (bus.mret && !bus.trap && !m_hnd);
         if (bus.csr_re) m_rdata = known ? old : 32'h0;
         pc_cyc = m_cyc;
         pc_ins = m_ins;
         m_cyc = m_cyc + 64'd1;
         if (bus.instret) m_ins = m_ins + 64'd1;
         if (wr) begin
            case (bus.csr_addr)
               12'h300: if (!mret_ok) begin m_mie = nv[3]; m_mpie = nv[7]; end
               12'h304: m_mier = nv & IMPL;
               12'h305: m_mtvec = nv[1] ? (nv & ~32'h3) : nv;
               12'h340: m_mscratch = nv;
               12'h341: m_mepc = nv & ~32'h3;
               12'h342: m_mcause = nv;
               12'hB00: m_cyc = {pc_cyc[63:32], nv};
               12'hB80: m_cyc = {nv, pc_cyc[31:0]};
               12'hB02: m_ins = {pc_ins[63:32], nv};
               12'hB82: m_ins = {nv, pc_ins[31:0]};
               default: ;
            endcase
         end
         if (bus.trap) begin
            m_mepc = bus.trap_pc & ~32'h3;
            m_mcause = bus.trap_cause;
            m_mpie = m_mie;
            m_mie = 0;
            if (m_hnd) m_df = 1;
            m_hnd = 1;
         end else if (mret_ok) begin
            m_mie = m_mpie;
            m_mpie = 1;
            m_hnd = 0;
         end
         m_mip = 32'h0;
         m_mip[3] = bus.irq[0];
         m_mip[7] = bus.irq[1];
         m_mip[11] = bus.irq[2];
         for (int i = 0; i < NL; i++) m_mip[16+i] = bus.irq[3+i];
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      logic [31:0] tgt;
      if (!rst) begin
         tgt = m_mtvec & ~32'h3;
         if (m_mtvec[1:0] == 2'b01 && bus.trap_cause[31])
            tgt = tgt + (bus.trap_cause << 2);
         chk("m_rdata",   bus.csr_rdata, m_rdata);
         chk("m_illegal", 32'(bus.csr_illegal), 32'(m_ill));
         chk("m_mepc",    bus.mepc, m_mepc);
         chk("m_handler", 32'(bus.in_handler), 32'(m_hnd));
         chk("m_dfault",  32'(bus.double_fault), 32'(m_df));
         chk("m_pending", 32'(bus.irq_pending), 32'(m_mie && (|(m_mip & m_mier)) && !m_hnd));
         chk("m_target",  bus.trap_target, tgt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.csr_op = 2'b00; bus.csr_re = 1'b0; bus.trap = 1'b0;
      bus.mret = 1'b0; bus.instret = 1'b0;
   endtask

   task automatic cop(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d,
                      input bit exp_ill, input string name);
      bus.csr_addr = a; bus.csr_op = op; bus.csr_wdata = d;
      tick(); clr();
      chk(name, 32'(bus.csr_illegal), 32'(exp_ill));
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
      bus.csr_addr = a; bus.csr_re = 1'b1;
      tick(); clr();
      chk(name, bus.csr_rdata, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.csr_addr = '0; bus.csr_wdata = '0; bus.trap_cause = '0; bus.trap_pc = '0;
      bus.irq = '0; clr();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rdata", bus.csr_rdata, 32'h0);
      chk("rst_illegal", 32'(bus.csr_illegal), 32'h0);
      chk("rst_dfault", 32'(bus.double_fault), 32'h0);
      chk("rst_handler", 32'(bus.in_handler), 32'h0);
      tick();

      rd(12'h305, 32'h0000_0100, "rd_mtvec_reset");
      rd(12'hF14, HART, "rd_mhartid");
      rd(12'h7C0, 32'h0, "rd_unmapped");
      chk("unmapped_illegal", 32'(bus.csr_illegal), 32'h1);

      cop(12'h340, 2'b01, 32'hA5A5_A5A5, 1'b0, "wr_mscratch");
      cop(12'h340, 2'b10, 32'h0000_000F, 1'b0, "set_mscratch");
      cop(12'h340, 2'b11, 32'h0000_00A0, 1'b0, "clr_mscratch");
      rd(12'h340, 32'hA5A5_A50F, "rd_mscratch");
      cop(12'hF11, 2'b01, 32'h1234_5678, 1'b1, "wr_ro_illegal");
      rd(12'hF11, VENDOR, "rd_mvendorid");

      cop(12'h300, 2'b01, 32'h0000_0008, 1'b0, "wr_mstatus");
      cop(12'h304, 2'b01, 32'h0000_0080, 1'b0, "wr_mie");
      cop(12'h305, 2'b01, 32'h0000_0201, 1'b0, "wr_mtvec");
      bus.irq = 7'b000_0010;
      tick(); tick();
      chk("irq_pending", 32'(bus.irq_pending), 32'h1);
      bus.trap = 1'b1; bus.trap_cause = 32'h8000_0007; bus.trap_pc = 32'h0000_1002;
      #1 chk("trap_target", bus.trap_target, 32'h0000_021C);
      tick(); clr();
      chk("trap_mepc", bus.mepc, 32'h0000_1000);
      chk("trap_handler", 32'(bus.in_handler), 32'h1);
      chk("trap_pending", 32'(bus.irq_pending), 32'h0);
      rd(12'h300, 32'h0000_1880, "trap_mstatus");
      rd(12'h342, 32'h8000_0007, "trap_mcause");
      bus.mret = 1'b1;
      tick(); clr();
      chk("mret_handler", 32'(bus.in_handler), 32'h0);
      rd(12'h300, 32'h0000_1888, "mret_mstatus");
      bus.irq = '0;
      tick();

      bus.trap = 1'b1; bus.trap_cause = 32'h2; bus.trap_pc = 32'h40;
      tick(); clr();
      bus.trap = 1'b1; bus.trap_cause = 32'h3; bus.trap_pc = 32'h44;
      tick(); clr();
      chk("dfault_set", 32'(bus.double_fault), 32'h1);
      chk("dfault_mepc", bus.mepc, 32'h0000_0044);
      bus.mret = 1'b1;
      tick(); clr(); tick();
      chk("dfault_sticky", 32'(bus.double_fault), 32'h1);
      bus.mret = 1'b1;
      tick(); clr();
      chk("mret_run_illegal", 32'(bus.csr_illegal), 32'h1);

      cop(12'hB00, 2'b01, 32'hFFFF_FFFE, 1'b0, "wr_mcycle");
      cop(12'hB80, 2'b01, 32'hFFFF_FFFF, 1'b0, "wr_mcycleh");
      rd(12'hB00, 32'hFFFF_FFFE, "mcycle_pre");
      rd(12'hB80, 32'hFFFF_FFFF, "mcycleh_pre");
      rd(12'hB00, 32'h0, "mcycle_wrap");
      rd(12'hB80, 32'h0, "mcycleh_wrap");
      cop(12'hB02, 2'b01, 32'hFFFF_FFFF, 1'b0, "wr_minstret");
      bus.instret = 1'b1;
      tick(); clr();
      rd(12'hB82, 32'h0000_0001, "minstreth_carry");

      cop(12'h305, 2'b01, 32'h0000_0302, 1'b0, "wr_mtvec_warl");
      rd(12'h305, 32'h0000_0300, "rd_mtvec_warl");
      cop(12'h341, 2'b01, 32'h0000_1003, 1'b0, "wr_mepc_warl");
      rd(12'h341, 32'h0000_1000, "rd_mepc_warl");
      cop(12'h304, 2'b01, 32'hFFFF_FFFF, 1'b0, "wr_mie_all");
      rd(12'h304, IMPL, "rd_mie_warl");
      bus.irq = 7'b000_1000;
      tick(); tick();
      cop(12'h344, 2'b01, 32'h0, 1'b0, "wr_mip_ignored");
      rd(12'h344, 32'h0001_0000, "rd_mip_local");
      bus.irq = '0;

      bus.csr_addr = 12'h340; bus.csr_op = 2'b01; bus.csr_wdata = 32'h1234;
      bus.trap = 1'b1; bus.trap_cause = 32'h5; bus.trap_pc = 32'h80;
      tick(); clr();
      rd(12'h340, 32'hA5A5_A50F, "trap_drops_write");
      bus.mret = 1'b1;
      tick(); clr();

      bus.trap = 1'b1; bus.trap_cause = 32'h7; bus.trap_pc = 32'h2000;
      rst = 1'b1;
      tick(); clr();
      rst = 1'b0;
      tick();
      chk("rst_mid_mepc", bus.mepc, 32'h0);
      chk("rst_mid_handler", 32'(bus.in_handler), 32'h0);
      rd(12'h305, 32'h0000_0100, "rst_mid_mtvec");
      rd(12'h340, 32'h0, "rst_mid_mscratch");
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
